lhca_arbiter: RTL and testbench
===============================

Name: lhca_arbiter

Overview:
- Shares one lhca instance among NUM_REQ requesters and sequences it.
- After reset or a reseed request, it injects a non-zero seed through the LHCA `source` input. It then discards WARMUP states before serving anything.
- In service, it hands each granted requester a distinct LHCA state word through a registered per-requester slot with a valid/ready handshake.
- It sits between the lhca datapath and the consumers: scramblers, test-pattern engines, dither logic.

Parameters:
- WIDTH, 32: LHCA width; must match the lhca instance (2..64).
- NUM_REQ, 4: number of requesters (>=2).
- WARMUP, 64: number of LHCA steps discarded after seeding (>=1).
- SEED, WIDTH'(1): non-zero value XORed into `source` during the seed cycle.

Ports:
- clk, input, 1: clock.
- reset_n, input, 1: asynchronous, active-low reset.
- reseed, input, 1: pulse; restarts the SEED/WARM sequence.
- entropy_en, input, 1: when 1, entropy_in is mixed into the LHCA while in WARM and RUN.
- entropy_in, input, WIDTH: true-random source bits (e.g. ring oscillators).
- lhca_source, output, WIDTH: drives the lhca `source` port.
- lhca_state, input, WIDTH: the lhca `state` output.
- req, input, NUM_REQ: level request, one bit per requester.
- rsp_valid, output, NUM_REQ: slot i holds an undelivered word.
- rsp_ready, input, NUM_REQ: requester i accepts its slot.
- rsp_data, output, NUM_REQ*WIDTH: slot i occupies bits [i*WIDTH +: WIDTH].
- warm, output, 1: 1 while in RUN.

Behaviour:
- FSM states:
  - SEED: one cycle; lhca_source = SEED; next state WARM.
  - WARM: lhca_source = entropy_en ? entropy_in : 0; counts WARMUP cycles; then RUN.
  - RUN: lhca_source = entropy_en ? entropy_in : 0, except during lock-up recovery (below).
- Reset (reset_n low, asynchronous):
  - FSM = SEED, warm-up counter = 0, rr pointer = 0.
  - rsp_valid = 0, rsp_data = 0, warm = 0.
- Timing from reset release: the first clock edge ends SEED. RUN and warm=1 begin WARMUP+1 cycles after release.
- lhca_source is combinational from FSM registers, entropy_in and lhca_state. The lhca register samples it at the same edge the controller updates.
- Eligibility: requester i is eligible when FSM==RUN, req[i]=1 and rsp_valid[i]=0. A slot is refilled no earlier than the cycle after its handshake.
- Grant: at most one per cycle, chosen round-robin.
  - The winner's slot loads lhca_state on the next edge and sets rsp_valid.
  - Latency is 1 cycle: request evaluated in cycle t, rsp_valid high in cycle t+1.
  - The rr pointer moves to winner+1 mod NUM_REQ. The pointer is unchanged when nothing is granted.
- Distinctness: the LHCA advances every cycle and only one grant happens per cycle. Words delivered between reseeds are therefore successive, never-repeated LHCA states.
- Hold: rsp_data[i] and rsp_valid[i] stay stable until rsp_ready[i]=1 while rsp_valid[i]=1. At that edge rsp_valid[i] clears; rsp_data[i] holds its old value.
- rsp_ready[i] with rsp_valid[i]=0 is ignored.
- Lock-up recovery (RUN only): if lhca_state == 0 in a cycle, then in that cycle:
  - lhca_source = SEED;
  - no grant is issued;
  - the word 0 is never delivered.
- reseed=1 in any FSM state goes to SEED on the next edge and clears warm.
  - Filled slots keep their data and stay valid until handshaken.
  - No new grants are issued until RUN.
  - reseed held high keeps the FSM in SEED.
- reseed and a grant in the same cycle: the grant completes and the FSM moves to SEED.
- Warm-up counter: $clog2(WARMUP+1) bits; saturates; cleared on entry to SEED.
- The lhca instance has no reset. The bench deposits 0 on its state at time 0; the SEED cycle then makes the state equal SEED.

Decomposition:
- lhca_arbiter_pkg holds:
  - typedef enum logic [1:0] {ST_SEED, ST_WARM, ST_RUN} lhca_ctrl_state_t;
  - function rr_next(ptr, n).
- One sub-module, rr_arbiter #(N): inputs eligible[N] and ptr, output one-hot grant[N] (combinational).
- The lhca instance lives in the parent, not in lhca_arbiter.

Test Plan:
- Bring-up: WIDTH=8, NUM_REQ=2, WARMUP=4, SEED=8'h01, entropy_en=0; release reset at cycle 0.
  - Cycle 0: lhca_source=8'h01.
  - warm rises at cycle 5; no rsp_valid before cycle 6.
  - Delivered words match a software LHCA model (diagonal 8'h06, start state 0).
- Round-robin: req=2'b11, rsp_ready=2'b11 from RUN onward.
  - Grants alternate 0,1,0,1; each slot valid every other cycle.
  - Words are consecutive model states; no duplicates over 200 words.
- Backpressure: req[0]=1, rsp_ready[0]=0 for 10 cycles.
  - rsp_valid[0] and rsp_data[0] stay constant; requester 1 is still served every cycle it is eligible.
  - rsp_ready[0]=1 clears slot 0 at the next edge.
- Reseed mid-run: pulse reseed with slot 1 full.
  - warm drops next cycle; slot 1 still delivers its old word.
  - No grants for 5 cycles; the post-warm-up sequence replays the bring-up words.
- Lock-up: force lhca_state=0 for one RUN cycle.
  - lhca_source=SEED that cycle; no grant that cycle; no rsp_data word equals 0.
- Async reset: assert reset_n low mid-cycle with slots full.
  - rsp_valid=0 and warm=0 immediately, without a clock edge; the sequence restarts at SEED.

Source files
------------

// File: rtl/lhca_arbiter_pkg.sv
// lhca_arbiter_pkg: controller state encoding and the round-robin pointer helper.
package lhca_arbiter_pkg;

    typedef enum logic [1:0] {ST_SEED, ST_WARM, ST_RUN} lhca_ctrl_state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant to the first eligible requester at or after ptr, wrapping.
// Purely combinational; no state, no backpressure of its own.
module rr_arbiter #(
    parameter int N = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic [N-1:0] hi_oh;
    logic [N-1:0] lo_oh;
    logic         hi_hit;

    // Descending scan leaves the lowest matching index in each one-hot.
    always_comb begin
        hi_oh  = '0;
        lo_oh  = '0;
        hi_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                lo_oh    = '0;
                lo_oh[i] = 1'b1;
            end
            if (eligible[i] && (i >= int'(ptr))) begin
                hi_oh    = '0;
                hi_oh[i] = 1'b1;
                hi_hit   = 1'b1;
            end
        end
        grant = hi_hit ? hi_oh : lo_oh;
    end

endmodule

// File: rtl/lhca_arbiter.sv
// lhca_arbiter: seeds and warms a shared LHCA, then deals one state word per cycle to NUM_REQ slots.
// Latency 1 cycle req->rsp_valid; a full slot holds until rsp_ready and only stalls its own requester.
module lhca_arbiter
    import lhca_arbiter_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter int               NUM_REQ = 4,
    parameter int               WARMUP  = 64,
    parameter logic [WIDTH-1:0] SEED    = WIDTH'(1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     reseed,
    input  logic                     entropy_en,
    input  logic [WIDTH-1:0]         entropy_in,
    output logic [WIDTH-1:0]         lhca_source,
    input  logic [WIDTH-1:0]         lhca_state,
    input  logic [NUM_REQ-1:0]       req,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [NUM_REQ*WIDTH-1:0] rsp_data,
    output logic                     warm
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(WARMUP + 1);

    lhca_ctrl_state_t                st_q, st_d;
    logic [CW-1:0]                   cnt_q, cnt_d;
    logic [PW-1:0]                   ptr_q, ptr_d;
    logic [NUM_REQ-1:0]              valid_q, valid_d;
    logic [NUM_REQ-1:0][WIDTH-1:0]   data_q, data_d;
    logic                            warm_q, warm_d;

    logic                            lockup;
    logic [NUM_REQ-1:0]              eligible;
    logic [NUM_REQ-1:0]              grant;
    logic [PW-1:0]                   win;

    // An all-zero LHCA is a fixed point; re-inject the seed and withhold the word.
    assign lockup = (st_q == ST_RUN) && (lhca_state == '0);

    always_comb begin
        lhca_source = entropy_en ? entropy_in : '0;
        if (st_q == ST_SEED || lockup) begin
            lhca_source = SEED;
        end
    end

    assign eligible = (st_q == ST_RUN && !lockup) ? (req & ~valid_q) : '0;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant)
    );

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        win     = '0;

        case (st_q)
            ST_SEED: begin
                st_d  = ST_WARM;
                cnt_d = '0;
            end
            ST_WARM: begin
                if (cnt_q != CW'(WARMUP)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (cnt_q == CW'(WARMUP - 1)) begin
                    st_d = ST_RUN;
                end
            end
            default: st_d = st_q;
        endcase

        if (reseed) begin
            st_d  = ST_SEED;
            cnt_d = '0;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (valid_q[i] && rsp_ready[i]) begin
                valid_d[i] = 1'b0;
            end
            if (grant[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = lhca_state;
                win        = PW'(i);
            end
        end

        if (|grant) begin
            ptr_d = PW'(rr_next(int'(win), NUM_REQ));
        end

        warm_d = (st_d == ST_RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q    <= ST_SEED;
            cnt_q   <= '0;
            ptr_q   <= '0;
            valid_q <= '0;
            data_q  <= '0;
            warm_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            warm_q  <= warm_d;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_data  = data_q;
    assign warm      = warm_q;

endmodule

// File: tb/tb_lhca_arbiter.sv
// Bench for lhca_arbiter with a behavioural 8-cell LHCA as the shared parent instance.
// A cycle-count model predicts source, slot contents and warm every cycle.
module tb_lhca_arbiter;

    localparam int          W      = 8;
    localparam int          NR     = 2;
    localparam int          WARMUP = 4;
    localparam logic [W-1:0] SEED  = 8'h01;
    localparam logic [W-1:0] DIAG  = 8'h06;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               reseed = 1'b0;
    logic               entropy_en = 1'b0;
    logic [W-1:0]       entropy_in = '0;
    logic [W-1:0]       lhca_source;
    logic [W-1:0]       lhca_state_in;
    logic [NR-1:0]      req = '0;
    logic [NR-1:0]      rsp_valid;
    logic [NR-1:0]      rsp_ready = '0;
    logic [NR*W-1:0]    rsp_data;
    logic               warm;
    logic               force0 = 1'b0;
    logic [W-1:0]       lhca_q = 8'h00;

    int errors = 0;
    int checks = 0;

    // Model state: cycles since the seed cycle, LHCA copy, slot contents, scan start.
    int                    m_cyc;
    logic [W-1:0]          m_lhca = 8'h00;
    logic [NR-1:0]         m_vld;
    logic [NR-1:0][W-1:0]  m_dat;
    int                    m_p;
    logic                  m_warm;
    logic [W-1:0]          m_src;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] lhca_step(input logic [W-1:0] s, input logic [W-1:0] src);
        logic [W+1:0] e;
        logic [W-1:0] n;
        e = {1'b0, s, 1'b0};
        for (int i = 0; i < W; i++) n[i] = e[i] ^ e[i+2] ^ (DIAG[i] & s[i]) ^ src[i];
        return n;
    endfunction

    always @(posedge clk) lhca_q <= lhca_step(lhca_q, lhca_source);
    assign lhca_state_in = force0 ? 8'h00 : lhca_q;

    lhca_arbiter #(.WIDTH(W), .NUM_REQ(NR), .WARMUP(WARMUP), .SEED(SEED)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reseed      (reseed),
        .entropy_en  (entropy_en),
        .entropy_in  (entropy_in),
        .lhca_source (lhca_source),
        .lhca_state  (lhca_state_in),
        .req         (req),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .warm        (warm)
    );

    task automatic model_reset();
        m_cyc  = 0;
        m_vld  = '0;
        m_dat  = '0;
        m_p    = 0;
        m_warm = 1'b0;
    endtask

    task automatic model_tick();
        logic [W-1:0] seen;
        bit           run;
        int           gnt;
        int           idx;
        seen = force0 ? 8'h00 : m_lhca;
        run  = (m_cyc > WARMUP);
        if (m_cyc == 0 || (run && seen == 8'h00)) m_src = SEED;
        else m_src = entropy_en ? entropy_in : 8'h00;
        gnt = -1;
        if (run && seen != 8'h00) begin
            for (int k = 0; k < NR; k++) begin
                idx = (m_p + k) % NR;
                if (gnt < 0 && req[idx] && !m_vld[idx]) gnt = idx;
            end
        end
        for (int i = 0; i < NR; i++) if (m_vld[i] && rsp_ready[i]) m_vld[i] = 1'b0;
        if (gnt >= 0) begin
            m_vld[gnt] = 1'b1;
            m_dat[gnt] = seen;
            m_p        = (gnt + 1) % NR;
        end
        m_lhca = lhca_step(m_lhca, m_src);
        m_cyc  = reseed ? 0 : ((m_cyc < 10000) ? m_cyc + 1 : m_cyc);
        m_warm = (m_cyc > WARMUP);
    endtask

    task automatic drive(input logic [NR-1:0] r, input logic [NR-1:0] rdy, input bit rs, input bit f0);
        req       = r;
        rsp_ready = rdy;
        reseed    = rs;
        force0    = f0;
        #1;
        model_tick();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, warm} !== '0)
            $display("FAIL reset_outputs got valid=%b data=%h warm=%b required all zero", rsp_valid, rsp_data, warm);
        if ({rsp_valid, rsp_data, warm} !== '0) errors++;
        checks++;
        if (lhca_source !== SEED) begin
            errors++;
            $display("FAIL reset_source got=%h required=%h", lhca_source, SEED);
        end
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_bringup();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 2'b11, 1'b0, 1'b0);
            if (c == 0) begin
                checks++;
                if (lhca_source !== 8'h01) begin
                    errors++;
                    $display("FAIL bringup_seed_source got=%h required=01", lhca_source);
                end
            end
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL bringup_src c=%0d got=%h required=%h", c, lhca_source, m_src);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL bringup_out c=%0d got v=%b d=%h w=%b required v=%b d=%h w=%b",
                         c, rsp_valid, rsp_data, warm, m_vld, m_dat, m_warm);
            end
            checks++;
            if (warm !== 1'(c + 1 >= 5)) begin
                errors++;
                $display("FAIL bringup_warm cycle=%0d got=%b required=%b", c + 1, warm, (c + 1 >= 5));
            end
            if (c + 1 < 6) begin
                checks++;
                if (rsp_valid !== 2'b00) begin
                    errors++;
                    $display("FAIL bringup_early_valid cycle=%0d got=%b required=00", c + 1, rsp_valid);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_round_robin();
        logic [W-1:0]  words[$];
        logic [NR-1:0] prev_v;
        prev_v = rsp_valid;
        while (words.size() < 200) begin
            drive(2'b11, 2'b11, 1'b0, 1'b0);
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL rr_src got=%h required=%h", lhca_source, m_src);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL rr_out got v=%b d=%h w=%b required v=%b d=%h w=%b",
                         rsp_valid, rsp_data, warm, m_vld, m_dat, m_warm);
            end
            checks++;
            if ((rsp_valid ^ prev_v) !== 2'b11 || $countones(rsp_valid) != 1) begin
                errors++;
                $display("FAIL rr_alternate got=%b previous=%b required one slot flipping each cycle", rsp_valid, prev_v);
            end
            prev_v = rsp_valid;
            for (int i = 0; i < NR; i++) if (rsp_valid[i]) words.push_back(rsp_data[i*W +: W]);
            @(negedge clk);
        end
        for (int k = 0; k < words.size(); k++) begin
            if (k > 0) begin
                checks++;
                if (words[k] !== lhca_step(words[k-1], 8'h00)) begin
                    errors++;
                    $display("FAIL rr_consecutive k=%0d got=%h required=%h", k, words[k], lhca_step(words[k-1], 8'h00));
                end
            end
            for (int j = 0; j < k; j++) begin
                if (words[j] === words[k]) begin
                    errors++;
                    $display("FAIL rr_duplicate word=%h at %0d and %0d required distinct", words[k], j, k);
                end
            end
        end
        checks++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held = '0;
        bit           have = 0;
        int           n1 = 0;
        for (int c = 0; c < 10; c++) begin
            drive(2'b11, 2'b10, 1'b0, 1'b0);
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL bp_src got=%h required=%h", lhca_source, m_src);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL bp_out got v=%b d=%h w=%b required v=%b d=%h w=%b",
                         rsp_valid, rsp_data, warm, m_vld, m_dat, m_warm);
            end
            if (have) begin
                checks++;
                if (rsp_valid[0] !== 1'b1 || rsp_data[W-1:0] !== held) begin
                    errors++;
                    $display("FAIL bp_hold got v0=%b d0=%h required v0=1 d0=%h", rsp_valid[0], rsp_data[W-1:0], held);
                end
            end else if (rsp_valid[0]) begin
                have = 1;
                held = rsp_data[W-1:0];
            end
            if (rsp_valid[1]) n1++;
            @(negedge clk);
        end
        checks++;
        if (n1 != 5) begin
            errors++;
            $display("FAIL bp_slot1_rate got=%0d required=5 valid cycles of 10", n1);
        end
        drive(2'b11, 2'b11, 1'b0, 1'b0);
        tick();
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_data[W-1:0] !== held) begin
            errors++;
            $display("FAIL bp_release got v0=%b d0=%h required v0=0 d0=%h", rsp_valid[0], rsp_data[W-1:0], held);
        end
        checks++;
        if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
            errors++;
            $display("FAIL bp_release_out got v=%b d=%h required v=%b d=%h", rsp_valid, rsp_data, m_vld, m_dat);
        end
        @(negedge clk);
    endtask

    task automatic test_lockup();
        for (int c = 0; c < 12; c++) begin
            drive(2'b11, 2'b11, 1'b0, c == 3);
            if (c == 3) begin
                checks++;
                if (lhca_source !== SEED) begin
                    errors++;
                    $display("FAIL lockup_source got=%h required=%h", lhca_source, SEED);
                end
            end
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL lockup_src c=%0d got=%h required=%h", c, lhca_source, m_src);
            end
            tick();
            if (c == 3) begin
                checks++;
                if (rsp_valid !== 2'b00) begin
                    errors++;
                    $display("FAIL lockup_no_grant got=%b required=00", rsp_valid);
                end
            end
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL lockup_out c=%0d got v=%b d=%h required v=%b d=%h", c, rsp_valid, rsp_data, m_vld, m_dat);
            end
            for (int i = 0; i < NR; i++) begin
                if (rsp_valid[i]) begin
                    checks++;
                    if (rsp_data[i*W +: W] === 8'h00) begin
                        errors++;
                        $display("FAIL lockup_zero_word slot=%0d got=00 required non-zero", i);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reseed();
        logic [W-1:0] old1;
        for (int c = 0; c < 2; c++) begin
            drive(2'b10, 2'b01, 1'b0, 1'b0);
            tick();
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL reseed_fill got v=%b d=%h required v=%b d=%h", rsp_valid, rsp_data, m_vld, m_dat);
            end
            @(negedge clk);
        end
        old1 = rsp_data[2*W-1:W];
        drive(2'b00, 2'b00, 1'b1, 1'b0);
        tick();
        checks++;
        if (warm !== 1'b0 || rsp_valid !== 2'b10 || rsp_data[2*W-1:W] !== old1) begin
            errors++;
            $display("FAIL reseed_enter got w=%b v=%b d1=%h required w=0 v=10 d1=%h", warm, rsp_valid, rsp_data[2*W-1:W], old1);
        end
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            drive(2'b11, 2'b01, 1'b0, 1'b0);
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL reseed_src c=%0d got=%h required=%h", c, lhca_source, m_src);
            end
            tick();
            checks++;
            if (rsp_valid !== 2'b10 || rsp_data[2*W-1:W] !== old1) begin
                errors++;
                $display("FAIL reseed_no_grant c=%0d got v=%b d1=%h required v=10 d1=%h", c, rsp_valid, rsp_data[2*W-1:W], old1);
            end
            @(negedge clk);
        end
        for (int c = 0; c < 12; c++) begin
            drive(2'b11, 2'b11, 1'b0, 1'b0);
            tick();
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL reseed_after c=%0d got v=%b d=%h w=%b required v=%b d=%h w=%b",
                         c, rsp_valid, rsp_data, warm, m_vld, m_dat, m_warm);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            entropy_en = ($urandom_range(3) == 0);
            entropy_in = W'($urandom);
            drive(NR'($urandom), NR'($urandom), ($urandom_range(39) == 0), ($urandom_range(29) == 0));
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL rand_src c=%0d got=%h required=%h", c, lhca_source, m_src);
            end
            tick();
            checks++;
            if ({rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL rand_out c=%0d got v=%b d=%h w=%b required v=%b d=%h w=%b",
                         c, rsp_valid, rsp_data, warm, m_vld, m_dat, m_warm);
            end
            @(negedge clk);
        end
        entropy_en = 1'b0;
        entropy_in = '0;
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 13; c++) begin
            drive((c < 10) ? 2'b00 : 2'b11, 2'b00, 1'b0, 1'b0);
            tick();
            if (c < 12) @(negedge clk);
        end
        checks++;
        if (rsp_valid !== 2'b11) begin
            errors++;
            $display("FAIL areset_precondition got v=%b required 11", rsp_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_data, warm} !== '0) begin
            errors++;
            $display("FAIL areset_immediate got v=%b d=%h w=%b required all zero", rsp_valid, rsp_data, warm);
        end
        #1;
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 2'b11, 1'b0, 1'b0);
            checks++;
            if (lhca_source !== m_src) begin
                errors++;
                $display("FAIL areset_src c=%0d got=%h required=%h", c, lhca_source, m_src);
            end
            tick();
            checks++;
            if (warm !== 1'(c + 1 >= 5) || {rsp_valid, rsp_data, warm} !== {m_vld, m_dat, m_warm}) begin
                errors++;
                $display("FAIL areset_restart c=%0d got v=%b d=%h w=%b required v=%b d=%h w=%b",
                         c, rsp_valid, rsp_data, warm, m_vld, m_dat, m_warm);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_round_robin();
        test_backpressure();
        test_lockup();
        test_reseed();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
